axi_lite_slave_arb: RTL and testbench

- Parametrised successor of the team's AXI4-Lite register slave. Converts AXI4-Lite transactions into the simple user register interface.
- Adds the following:
  - independent AW/W capture in either order;
  - write byte strobes;
  - fair read/write arbitration;
  - a user-response watchdog that returns SLVERR.
- Sits between the AXI interconnect and a peripheral register file.

---
 rtl/axi_lite_slave_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_slave_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_arb.sv
// AXI4-Lite to user register bridge: AW, W and AR buffers with fair read/write arbitration and a watchdog that answers SLVERR.
// User request follows capture by 1 cycle and B/R follows the user strobe by 1 cycle; ready drops while each single-entry buffer is full.
module axi_lite_slave_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_awvalid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  output logic                    o_awready,
  input  logic                    i_wvalid,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [STROBE_WIDTH-1:0] i_wstrb,
  output logic                    o_wready,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [1:0]              o_bresp,
  input  logic                    i_arvalid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  output logic                    o_arready,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [1:0]              o_rresp,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [ADDR_WIDTH-1:0]   o_reg_address,
  output logic                    o_reg_in_rdy,
  input  logic                    i_reg_in_ack_stb,
  output logic [DATA_WIDTH-1:0]   o_reg_in_data,
  output logic [STROBE_WIDTH-1:0] o_reg_in_strb,
  output logic                    o_reg_out_req,
  input  logic                    i_reg_out_rdy_stb,
  input  logic [DATA_WIDTH-1:0]   i_reg_out_data,
  input  logic                    i_reg_invalid_addr
);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam bit                     TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic                     aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0]    aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_WIDTH-1:0]    w_data_q, w_data_d;
  logic [STROBE_WIDTH-1:0]  w_strb_q, w_strb_d;
  logic                     awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                     last_wr_q, last_wr_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]    reg_address_q, reg_address_d;
  logic                     reg_in_rdy_q, reg_in_rdy_d, reg_out_req_q, reg_out_req_d;
  logic                     bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]               bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     wr_pend, rd_pend, expired;

  always_comb begin
    state_d       = state_q;
    aw_full_d     = aw_full_q;
    w_full_d      = w_full_q;
    ar_full_d     = ar_full_q;
    aw_addr_d     = aw_addr_q;
    ar_addr_d     = ar_addr_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    last_wr_d     = last_wr_q;
    cnt_d         = cnt_q;
    reg_address_d = reg_address_q;
    reg_in_rdy_d  = reg_in_rdy_q;
    reg_out_req_d = reg_out_req_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    rvalid_d      = rvalid_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;

    if (i_awvalid && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = i_awaddr;
    end
    if (i_wvalid && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = i_wdata;
      w_strb_d = i_wstrb;
    end
    if (i_arvalid && arready_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = i_araddr;
    end

    wr_pend = aw_full_q && w_full_q;
    rd_pend = ar_full_q;
    expired = TO_EN && (cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        // Contention flips the priority; a lone request leaves it untouched.
        if (wr_pend && (!rd_pend || !last_wr_q)) begin
          state_d       = WR_WAIT;
          reg_address_d = aw_addr_q;
          reg_in_rdy_d  = 1'b1;
          cnt_d         = '0;
          if (rd_pend) last_wr_d = 1'b1;
        end else if (rd_pend) begin
          state_d       = RD_WAIT;
          reg_address_d = ar_addr_q;
          reg_out_req_d = 1'b1;
          cnt_d         = '0;
          if (wr_pend) last_wr_d = 1'b0;
        end
      end
      WR_WAIT: begin
        if (i_reg_in_ack_stb || expired) begin
          state_d      = WR_RESP;
          reg_in_rdy_d = 1'b0;
          bvalid_d     = 1'b1;
          bresp_d      = !i_reg_in_ack_stb ? RESP_SLVERR :
                         i_reg_invalid_addr ? RESP_DECERR : RESP_OKAY;
          aw_full_d    = 1'b0;
          w_full_d     = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_RESP: begin
        if (i_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_WAIT: begin
        if (i_reg_out_rdy_stb || expired) begin
          state_d       = RD_RESP;
          reg_out_req_d = 1'b0;
          rvalid_d      = 1'b1;
          rdata_d       = i_reg_out_rdy_stb ? i_reg_out_data : '0;
          rresp_d       = !i_reg_out_rdy_stb ? RESP_SLVERR :
                          i_reg_invalid_addr ? RESP_DECERR : RESP_OKAY;
          ar_full_d     = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_RESP: begin
        if (i_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
    arready_d = !ar_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      aw_full_q     <= 1'b0;
      w_full_q      <= 1'b0;
      ar_full_q     <= 1'b0;
      aw_addr_q     <= '0;
      ar_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      arready_q     <= 1'b0;
      last_wr_q     <= 1'b0;
      cnt_q         <= '0;
      reg_address_q <= '0;
      reg_in_rdy_q  <= 1'b0;
      reg_out_req_q <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      rvalid_q      <= 1'b0;
      rresp_q       <= 2'b00;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      aw_full_q     <= aw_full_d;
      w_full_q      <= w_full_d;
      ar_full_q     <= ar_full_d;
      aw_addr_q     <= aw_addr_d;
      ar_addr_q     <= ar_addr_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      arready_q     <= arready_d;
      last_wr_q     <= last_wr_d;
      cnt_q         <= cnt_d;
      reg_address_q <= reg_address_d;
      reg_in_rdy_q  <= reg_in_rdy_d;
      reg_out_req_q <= reg_out_req_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
    end
  end

  // The W buffer is frozen while a write is in flight, so it feeds the user port directly.
  assign o_reg_in_data = w_data_q;
  assign o_reg_in_strb = w_strb_q;
  assign o_awready     = awready_q;
  assign o_wready      = wready_q;
  assign o_arready     = arready_q;
  assign o_bvalid      = bvalid_q;
  assign o_bresp       = bresp_q;
  assign o_rvalid      = rvalid_q;
  assign o_rresp       = rresp_q;
  assign o_rdata       = rdata_q;
  assign o_reg_address = reg_address_q;
  assign o_reg_in_rdy  = reg_in_rdy_q;
  assign o_reg_out_req = reg_out_req_q;

endmodule

// File: tb/tb_axi_lite_slave_arb.sv
// Directed and randomised bench for axi_lite_slave_arb with an 8-cycle watchdog.
module tb_axi_lite_slave_arb;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_awvalid = 0, i_wvalid = 0, i_arvalid = 0, i_bready = 0, i_rready = 0;
  logic [31:0] i_awaddr = '0, i_araddr = '0, i_wdata = '0, i_reg_out_data = '0;
  logic [3:0]  i_wstrb = '0;
  logic        i_reg_in_ack_stb = 0, i_reg_out_rdy_stb = 0, i_reg_invalid_addr = 0;
  logic        o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_reg_in_rdy, o_reg_out_req;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata, o_reg_address, o_reg_in_data;
  logic [3:0]  o_reg_in_strb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_slave_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4),
                       .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
    .i_wvalid(i_wvalid), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_wready(o_wready),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .o_arready(o_arready),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
    .o_reg_address(o_reg_address), .o_reg_in_rdy(o_reg_in_rdy),
    .i_reg_in_ack_stb(i_reg_in_ack_stb), .o_reg_in_data(o_reg_in_data),
    .o_reg_in_strb(o_reg_in_strb), .o_reg_out_req(o_reg_out_req),
    .i_reg_out_rdy_stb(i_reg_out_rdy_stb), .i_reg_out_data(i_reg_out_data),
    .i_reg_invalid_addr(i_reg_invalid_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected response from the user behaviour: a strobe within the window wins, otherwise SLVERR.
  function automatic logic [1:0] exp_resp(input int d, input bit inv);
    if (d < TO) return inv ? 2'b11 : 2'b00;
    return 2'b10;
  endfunction

  task automatic send_aw(input logic [31:0] addr);
    logic r = 0;
    i_awvalid = 1; i_awaddr = addr;
    for (int k = 0; k < 50; k++) begin r = o_awready; tick(); if (r) break; end
    i_awvalid = 0;
    chk("aw_handshake", r, 1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    logic r = 0;
    i_wvalid = 1; i_wdata = data; i_wstrb = strb;
    for (int k = 0; k < 50; k++) begin r = o_wready; tick(); if (r) break; end
    i_wvalid = 0;
    chk("w_handshake", r, 1);
  endtask

  task automatic send_ar(input logic [31:0] addr);
    logic r = 0;
    i_arvalid = 1; i_araddr = addr;
    for (int k = 0; k < 50; k++) begin r = o_arready; tick(); if (r) break; end
    i_arvalid = 0;
    chk("ar_handshake", r, 1);
  endtask

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic ra, rw;
    i_awvalid = 1; i_awaddr = addr; i_wvalid = 1; i_wdata = data; i_wstrb = strb;
    for (int k = 0; k < 50 && (i_awvalid || i_wvalid); k++) begin
      ra = o_awready; rw = o_wready;
      tick();
      if (ra) i_awvalid = 0;
      if (rw) i_wvalid = 0;
    end
    chk("aw_w_handshake", {i_awvalid, i_wvalid}, 2'b00);
    i_awvalid = 0; i_wvalid = 0;
  endtask

  task automatic user_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int d, input bit inv);
    int n = 0;
    for (int k = 0; k < 50 && !o_reg_in_rdy; k++) tick();
    chk("wr_req", o_reg_in_rdy, 1);
    chk("wr_addr", o_reg_address, addr);
    chk("wr_data", o_reg_in_data, data);
    chk("wr_strb", o_reg_in_strb, strb);
    for (int c = 0; c < 40; c++) begin
      if (!o_reg_in_rdy) break;
      n++;
      if (c == d) begin
        i_reg_in_ack_stb = 1; i_reg_invalid_addr = inv;
        tick();
        i_reg_in_ack_stb = 0; i_reg_invalid_addr = 0;
        break;
      end
      tick();
    end
    chk("wr_req_cycles", n, (d < TO) ? d + 1 : TO);
    chk("bvalid_rise", o_bvalid, 1);
    chk("bresp", o_bresp, exp_resp(d, inv));
    chk("wr_req_drop", o_reg_in_rdy, 0);
  endtask

  task automatic user_rd(input logic [31:0] addr, input logic [31:0] data, input int d, input bit inv);
    int n = 0;
    for (int k = 0; k < 50 && !o_reg_out_req; k++) tick();
    chk("rd_req", o_reg_out_req, 1);
    chk("rd_addr", o_reg_address, addr);
    i_reg_out_data = ~data;
    for (int c = 0; c < 40; c++) begin
      if (!o_reg_out_req) break;
      n++;
      if (c == d) begin
        i_reg_out_rdy_stb = 1; i_reg_invalid_addr = inv; i_reg_out_data = data;
        tick();
        i_reg_out_rdy_stb = 0; i_reg_invalid_addr = 0; i_reg_out_data = ~data;
        break;
      end
      tick();
    end
    chk("rd_req_cycles", n, (d < TO) ? d + 1 : TO);
    chk("rvalid_rise", o_rvalid, 1);
    chk("rresp", o_rresp, exp_resp(d, inv));
    chk("rdata", o_rdata, (d < TO) ? data : 32'h0);
  endtask

  task automatic b_resp(input int hold, input logic [1:0] exp);
    for (int i = 0; i < hold; i++) begin
      chk("bvalid_hold", o_bvalid, 1);
      chk("bresp_hold", o_bresp, exp);
      tick();
    end
    i_bready = 1; tick(); i_bready = 0;
    chk("bvalid_fall", o_bvalid, 0);
  endtask

  task automatic r_resp(input int hold, input logic [1:0] exp, input logic [31:0] data);
    for (int i = 0; i < hold; i++) begin
      chk("rvalid_hold", o_rvalid, 1);
      chk("rresp_hold", o_rresp, exp);
      chk("rdata_hold", o_rdata, data);
      tick();
    end
    i_rready = 1; tick(); i_rready = 0;
    chk("rvalid_fall", o_rvalid, 0);
  endtask

  task automatic present_all(input logic [31:0] awa, input logic [31:0] wd, input logic [31:0] ara);
    chk("all_ready", {o_awready, o_wready, o_arready}, 3'b111);
    i_awvalid = 1; i_awaddr = awa; i_wvalid = 1; i_wdata = wd; i_wstrb = 4'hF;
    i_arvalid = 1; i_araddr = ara;
    tick();
    i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
    chk("all_ready_low", {o_awready, o_wready, o_arready}, 3'b000);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    int kind, order, d, hold;
    bit inv;
    logic [31:0] addr, data;
    logic [3:0] strb;

    // Reset state and release
    repeat (3) tick();
    chk("rst_outputs", {o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_reg_in_rdy, o_reg_out_req}, 7'b0);
    chk("rst_resp", {o_bresp, o_rresp, o_rdata}, 36'h0);
    rst_n = 1;
    chk("ready_before_edge", {o_awready, o_wready, o_arready}, 3'b000);
    tick();
    chk("ready_after_release", {o_awready, o_wready, o_arready}, 3'b111);

    // First contention goes to the write, the next one to the read
    present_all(32'h100, 32'h1111_0000, 32'h200);
    chk("cont1_write", {o_reg_in_rdy, o_reg_out_req}, 2'b10);
    user_wr(32'h100, 32'h1111_0000, 4'hF, 0, 0);
    b_resp(0, 2'b00);
    user_rd(32'h200, 32'h2222_0000, 0, 0);
    r_resp(0, 2'b00, 32'h2222_0000);
    present_all(32'h104, 32'h3333_0000, 32'h204);
    chk("cont2_read", {o_reg_in_rdy, o_reg_out_req}, 2'b01);
    user_rd(32'h204, 32'h4444_0000, 1, 0);
    r_resp(1, 2'b00, 32'h4444_0000);
    user_wr(32'h104, 32'h3333_0000, 4'hF, 1, 0);
    b_resp(1, 2'b00);

    // W ahead of AW, partial strobes, ack after 2 cycles
    send_w(32'hA5A5_0004, 4'b0011);
    tick(); tick();
    send_aw(32'h10);
    chk("wr_req_not_yet", o_reg_in_rdy, 0);
    tick();
    chk("wr_req_latency", o_reg_in_rdy, 1);
    user_wr(32'h10, 32'hA5A5_0004, 4'b0011, 2, 0);
    b_resp(3, 2'b00);

    // Stray strobes outside a wait state do nothing
    i_reg_in_ack_stb = 1; i_reg_out_rdy_stb = 1; i_reg_invalid_addr = 1;
    tick();
    i_reg_in_ack_stb = 0; i_reg_out_rdy_stb = 0; i_reg_invalid_addr = 0;
    tick();
    chk("stray_strobe", {o_bvalid, o_rvalid}, 2'b00);

    // DECERR read, then watchdog expiry and ack on the expiry cycle
    send_ar(32'h20);
    user_rd(32'h20, 32'hDEAD_BEEF, 1, 1);
    r_resp(2, 2'b11, 32'hDEAD_BEEF);
    send_ar(32'h30);
    user_rd(32'h30, 32'h1234_5678, 1000, 0);
    r_resp(1, 2'b10, 32'h0);
    send_ar(32'h34);
    user_rd(32'h34, 32'h8765_4321, TO - 1, 0);
    r_resp(0, 2'b00, 32'h8765_4321);

    // B held for 10 cycles while the next write is buffered
    send_aw_w(32'h60, 32'hCAFE_0001, 4'hF);
    user_wr(32'h60, 32'hCAFE_0001, 4'hF, 0, 0);
    i_awvalid = 1; i_awaddr = 32'h64; i_wvalid = 1; i_wdata = 32'hCAFE_0002; i_wstrb = 4'b0000;
    tick();
    i_awvalid = 0; i_wvalid = 0;
    chk("buffered_ready_low", {o_awready, o_wready}, 2'b00);
    for (int i = 0; i < 9; i++) begin
      chk("b_stall_valid", o_bvalid, 1);
      chk("b_stall_resp", o_bresp, 2'b00);
      chk("b_stall_no_req", o_reg_in_rdy, 0);
      tick();
    end
    i_bready = 1; tick(); i_bready = 0;
    chk("b_stall_fall", {o_bvalid, o_reg_in_rdy}, 2'b00);
    tick();
    chk("buffered_start", o_reg_in_rdy, 1);
    user_wr(32'h64, 32'hCAFE_0002, 4'b0000, 3, 0);
    b_resp(0, 2'b00);

    // Randomised transactions against the response model
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 1);
      order = $urandom_range(0, 2);
      addr = $urandom & 32'hFFFC;
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      d = $urandom_range(0, 11);
      inv = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      if (kind == 0) begin
        if (order == 0) begin send_aw(addr); send_w(data, strb); end
        else if (order == 1) begin send_w(data, strb); send_aw(addr); end
        else send_aw_w(addr, data, strb);
        user_wr(addr, data, strb, d, inv);
        b_resp(hold, exp_resp(d, inv));
      end else begin
        send_ar(addr);
        user_rd(addr, data, d, inv);
        r_resp(hold, exp_resp(d, inv), (d < TO) ? data : 32'h0);
      end
    end

    // Reset during a read wait aborts everything
    send_ar(32'h40);
    tick();
    chk("abort_req_up", o_reg_out_req, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_async", {o_reg_out_req, o_rvalid, o_awready, o_wready, o_arready, o_reg_in_rdy, o_bvalid}, 7'b0);
    @(posedge clk); #1 rst_n = 1;
    tick();
    chk("abort_ready_back", {o_awready, o_wready, o_arready}, 3'b111);
    tick();
    chk("abort_discarded", o_reg_out_req, 0);
    send_aw_w(32'h50, 32'h0BAD_F00D, 4'b1010);
    user_wr(32'h50, 32'h0BAD_F00D, 4'b1010, 1, 0);
    b_resp(1, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
